// File: rtl/sudoku_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sudoku_checker
// Brief    : Scans a loaded 9x9 grid row/column/box-wise and reports the first
//            invalid unit. Optional macro SUDOKU_ALLOW_BLANK_EN treats 0 as blank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sudoku_checker #(
   parameter int CELL_W = 4,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [IDX_W-1:0]  rd_row,
   output logic [IDX_W-1:0]  rd_col,
   input  logic [CELL_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_unit,
   output logic [IDX_W-1:0]  err_index
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0]  c_EIGHT = IDX_W'(8);
   localparam logic [CELL_W-1:0] c_ONE   = CELL_W'(1);
   localparam logic [CELL_W-1:0] c_NINE  = CELL_W'(9);

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_p;
   logic [IDX_W-1:0]    r_u;
   logic [IDX_W-1:0]    r_k;
   logic                r_chk_vld;
   logic [1:0]          r_dp;
   logic [IDX_W-1:0]    r_du;
   logic [IDX_W-1:0]    r_dk;
   logic [8:0]          r_seen;
   logic                r_err;
   logic [1:0]          r_err_unit;
   logic [IDX_W-1:0]    r_err_index;
   logic                w_last;
   logic                w_accept;
   logic [8:0]          w_base;
   logic [8:0]          w_onehot;
   logic                w_inrange;
   logic                w_bad;

   // 3*(x/3) and x/3 for x in 0..8
   function automatic logic [IDX_W-1:0] f_base3(input logic [IDX_W-1:0] x);
      if (x < IDX_W'(3))      return IDX_W'(0);
      else if (x < IDX_W'(6)) return IDX_W'(3);
      else                    return IDX_W'(6);
   endfunction

   function automatic logic [IDX_W-1:0] f_div3(input logic [IDX_W-1:0] x);
      if (x < IDX_W'(3))      return IDX_W'(0);
      else if (x < IDX_W'(6)) return IDX_W'(1);
      else                    return IDX_W'(2);
   endfunction

   assign w_last   = (r_p == 2'd2) && (r_u == c_EIGHT) && (r_k == c_EIGHT);
   assign w_accept = (r_state == S_IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      rd_en  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_READ;
         S_READ: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (w_last) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Counters wrap back to zero on the final address, so IDLE always sees 0/0/0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p <= 2'd0;
         r_u <= '0;
         r_k <= '0;
      end else if (r_state == S_READ) begin
         if (r_k == c_EIGHT) begin
            r_k <= '0;
            if (r_u == c_EIGHT) begin
               r_u <= '0;
               r_p <= (r_p == 2'd2) ? 2'd0 : r_p + 2'd1;
            end else begin
               r_u <= r_u + IDX_W'(1);
            end
         end else begin
            r_k <= r_k + IDX_W'(1);
         end
      end
   end

   always_comb begin
      rd_row = r_u;
      rd_col = r_k;
      case (r_p)
         2'd0: begin
            rd_row = r_u;
            rd_col = r_k;
         end
         2'd1: begin
            rd_row = r_k;
            rd_col = r_u;
         end
         default: begin
            rd_row = f_base3(r_u) + f_div3(r_k);
            rd_col = IDX_W'(3) * (r_u - f_base3(r_u)) + (r_k - f_base3(r_k));
         end
      endcase
   end

   assign w_base    = (r_dk == '0) ? 9'd0 : r_seen;
   assign w_inrange = (rd_data >= c_ONE) && (rd_data <= c_NINE);
   assign w_onehot  = w_inrange ? (9'd1 << (rd_data - c_ONE)) : 9'd0;

`ifdef SUDOKU_ALLOW_BLANK_EN
   assign w_bad = (rd_data != '0) && (!w_inrange || (|(w_base & w_onehot)));
`else
   assign w_bad = !w_inrange || (|(w_base & w_onehot));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_vld   <= 1'b0;
         r_dp        <= 2'd0;
         r_du        <= '0;
         r_dk        <= '0;
         r_seen      <= 9'd0;
         r_err       <= 1'b0;
         r_err_unit  <= 2'd0;
         r_err_index <= '0;
      end else begin
         r_chk_vld <= rd_en;
         r_dp      <= r_p;
         r_du      <= r_u;
         r_dk      <= r_k;
         if (r_chk_vld) r_seen <= w_base | w_onehot;
         if (w_accept) begin
            r_err       <= 1'b0;
            r_err_unit  <= 2'd0;
            r_err_index <= '0;
         end else if (r_chk_vld && w_bad && !r_err) begin
            r_err       <= 1'b1;
            r_err_unit  <= r_dp;
            r_err_index <= r_du;
         end
      end
   end

   assign err       = r_err;
   assign err_unit  = r_err_unit;
   assign err_index = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_sudoku_checker
// Brief    : Directed self-checking bench for sudoku_checker with a registered
//            grid read model; honours SUDOKU_ALLOW_BLANK_EN for the blank case.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sudoku_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rd_en;
   logic [3:0] rd_row;
   logic [3:0] rd_col;
   logic [3:0] rd_data;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_unit;
   logic [3:0] err_index;

   logic [3:0] grid [0:8][0:8];

   int checks = 0;
   int errors = 0;

   int         en_cnt;
   int         done_cyc;
   int         done_cnt;
   logic       busy_after;
   logic       err_at1;
   logic       d_err;
   logic [1:0] d_unit;
   logic [3:0] d_idx;

   sudoku_checker #(.CELL_W(4), .IDX_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_en     (rd_en),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_unit  (err_unit),
      .err_index (err_index)
   );

   always #5 clk = ~clk;

   // Loader model: registered read; junk when not strobed so stray sampling shows up
   always @(posedge clk) begin
      if (rd_en && rd_row < 4'd9 && rd_col < 4'd9) rd_data <= grid[rd_row][rd_col];
      else                                        rd_data <= 4'hF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_solved();
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            grid[r][c] = 4'((3*r + r/3 + c) % 9 + 1);
   endtask

   task automatic run_scan(input int pulse_at);
      en_cnt = 0; done_cyc = 0; done_cnt = 0;
      busy_after = 1'b1; err_at1 = 1'b1;
      d_err = 1'b0; d_unit = 2'd0; d_idx = 4'd0;
      @(negedge clk) start = 1'b1;
      for (int cyc = 1; cyc <= 250; cyc++) begin
         @(negedge clk);
         start = (cyc == pulse_at);
         if (cyc == 1) err_at1 = err;
         if (rd_en) en_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = cyc;
               d_err = err; d_unit = err_unit; d_idx = err_index;
            end
         end
         if (cyc == 246) busy_after = busy;
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string tag, input logic e, input logic [1:0] u, input logic [3:0] i);
      check({tag, "_rd_en_cycles"}, en_cnt, 243);
      check({tag, "_done_cycle"}, done_cyc, 245);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_busy_after"}, busy_after, 0);
      check({tag, "_err_cleared"}, err_at1, 0);
      check({tag, "_err"}, d_err, e);
      check({tag, "_err_unit"}, d_unit, u);
      check({tag, "_err_index"}, d_idx, i);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      fill_solved();
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_err", err, 0);
      check("rst_err_unit", err_unit, 0);
      check("rst_err_index", err_index, 0);
      check("rst_rd_row", rd_row, 0);
      check("rst_rd_col", rd_col, 0);
      rst = 1'b0;
      @(negedge clk);

      // Solved grid, with stray start pulses during READ
      run_scan(0);
      check_run("solved", 1'b0, 2'd0, 4'd0);
      run_scan(50);
      check_run("solved_pulse", 1'b0, 2'd0, 4'd0);

      // Swap (0,0)/(0,1): row clean, column 0 duplicates row 3
      grid[0][0] = 4'd2; grid[0][1] = 4'd1;
      run_scan(0);
      check_run("swap", 1'b1, 2'd1, 4'd0);

      // Failing then passing: err must clear at the second start
      fill_solved();
      run_scan(0);
      check_run("pass_after_fail", 1'b0, 2'd0, 4'd0);

      grid[4][4] = 4'd11;
      run_scan(0);
      check_run("oor", 1'b1, 2'd0, 4'd4);

      fill_solved();
      grid[2][3] = 4'd0;
      run_scan(0);
`ifdef SUDOKU_ALLOW_BLANK_EN
      check_run("blank", 1'b0, 2'd0, 4'd0);
`else
      check_run("blank", 1'b1, 2'd0, 4'd2);
`endif

      // Latin square: rows and columns valid, box 0 holds 2 twice
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            grid[r][c] = 4'((r + c) % 9 + 1);
      run_scan(0);
      check_run("box", 1'b1, 2'd2, 4'd0);

      // Reset in the middle of a scan
      fill_solved();
      @(negedge clk) start = 1'b1;
      for (int cyc = 1; cyc < 100; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      check("abort_rd_row", rd_row, 0);
      @(negedge clk) rst = 1'b0;
      done_cnt = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_idle_busy", busy, 0);

      run_scan(0);
      check_run("after_abort", 1'b0, 2'd0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
